wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RV32E core. Accepts one retiring instruction per cycle from execute, either a finished ALU result or a pending load. It waits for load data from the data-memory port and sign- or zero-extends it. It drives the single registered write port of the 16-entry register file; that port also serves as the bypass source for decode.

## Interface
Parameters:
- LOAD_TIMEOUT, 16: max cycles spent in WAIT_LOAD before abandoning the load; must be ≥2.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  execute presents a retiring instruction
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready
- ex_rd  in  5  destination register index
- ex_result  in  32  ALU result (ignored for loads)
- ex_is_load  in  1  instruction is a load
- ex_funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ex_addr_lo  in  2  load address bits [1:0]
- mem_rvalid  in  1  load data valid (single-cycle pulse)
- mem_rdata  in  32  aligned 32-bit word from data memory
- rd  out  5  register-file write index
- write_data  out  32  register-file write data
- write_enable  out  1  register-file write strobe
- err  out  1  sticky error flag, cleared only by rst

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE: ex_ready=1.
  - Non-load accept: capture rd/result into the write-port registers; write_enable=1 next cycle.
  - Load accept: capture rd, funct3, addr_lo; clear timeout counter; go to WAIT_LOAD.
- WAIT_LOAD: ex_ready=0; counter increments each cycle.
  - On mem_rvalid: write-port registers get the formatted data; write_enable=1 next cycle; return to IDLE.
  - If the counter reaches LOAD_TIMEOUT-1 without mem_rvalid: no write, set err, return to IDLE.
- Load formatting:
  - LB/LBU select byte mem_rdata[8*addr_lo +: 8]; LH/LHU select half mem_rdata[16*addr_lo[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Write suppression, all of which set err except ex_rd=0:
  - ex_rd=0: write_enable stays 0, err not set.
  - ex_rd[4]=1: outside RV32E; write_enable stays 0, err set.
  - Misaligned LH/LHU (addr_lo[0]=1): treated as halfword addr_lo[1]; err set.
  - Misaligned LW (addr_lo≠0): word passed unchanged; err set.
  - Unsupported funct3 (011, 110, 111): formatted as LW; err set.
- mem_rvalid in IDLE: ignored, sets err.
- write_enable is high for exactly one cycle per committed instruction; rd/write_data hold their last value while it is low.

## Timing
- Reset values: write_enable=0, rd=0, write_data=0, err=0, state=IDLE, counter=0.
- ex_ready=1 from the first cycle after reset.
- ALU path: accept in cycle N → write_enable in N+1. Back-to-back accepts every cycle give back-to-back writes.
- Load path: accept in cycle N; earliest legal mem_rvalid is N+1; rvalid in cycle M → write_enable in M+1.
- ex_ready: 0 from N+1 through M, 1 again in M+1. A new accept in M+1 coincides with the load's write.
- Timeout: with no rvalid, return to IDLE in cycle N+LOAD_TIMEOUT, err set in the same cycle, no write.
- rst mid-load: abandons the load immediately; a pending write_enable is dropped.

## Structure
- Shared package wb_pkg holds:
  - the funct3 load-encoding constants;
  - the wb_state_e enum (IDLE, WAIT_LOAD);
  - a load_req_t struct {rd, funct3, addr_lo}.
- One combinational sub-module, load_align: inputs funct3, addr_lo, word; outputs data and misalign/illegal flags. It is reused later by the store path tests.

## Test plan
- ALU writes: accept rd=3 result 0xDEADBEEF, then rd=4 result 0x1 on consecutive cycles → write_enable high two cycles, write_data 0xDEADBEEF then 0x1, err=0.
- Sign/zero extension: LB addr_lo=3, mem_rdata 0x80112233, rvalid 2 cycles after accept → write 0xFFFFFF80 one cycle after rvalid. Same stimulus as LBU → 0x00000080. LHU addr_lo=2 → 0x00008011.
- Back-pressure: load accepted, rvalid after 5 cycles → ex_ready low exactly 5 cycles. ALU instruction held on ex_valid is accepted the cycle after rvalid, writes the cycle after that.
- Timeout: LOAD_TIMEOUT=4, no rvalid → stage back in IDLE 4 cycles after accept, err=1, no write_enable. A later rvalid is ignored.
- Suppression: ALU rd=0 → no write, err=0. ALU rd=17 → no write, err=1. LW addr_lo=1 → write occurs, err=1.
- Reset: assert rst asynchronously during WAIT_LOAD → outputs zero immediately, ex_ready=1 after release, no write from the abandoned load.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: load encodings, FSM states, load request record.
package wb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    logic [1:0]       addr_lo;
  } load_req_t;

endpackage

// File: rtl/wb_if.sv
// Execute/data-memory/register-file signal bundle seen by the writeback stage.
interface wb_if;
  import wb_pkg::*;

  logic             ex_valid;
  logic             ex_ready;
  logic [REG_W-1:0] ex_rd;
  logic [XLEN-1:0]  ex_result;
  logic             ex_is_load;
  logic [2:0]       ex_funct3;
  logic [1:0]       ex_addr_lo;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic [REG_W-1:0] rd;
  logic [XLEN-1:0]  write_data;
  logic             write_enable;
  logic             err;

  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    output mem_rvalid, mem_rdata,
    input  ex_ready, rd, write_data, write_enable, err
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    input  mem_rvalid, mem_rdata,
    output ex_ready, rd, write_data, write_enable, err
  );

endinterface

// File: rtl/load_align.sv
// Selects and extends the addressed byte/half/word of a load; flags misaligned and unknown encodings.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            misalign,
  output logic            illegal
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Misaligned halves fall back to the half chosen by addr_lo[1]; odd encodings pass the word.
  always_comb begin
    b_sel    = word[{addr_lo, 3'b000} +: 8];
    h_sel    = word[{addr_lo[1], 4'b0000} +: 16];
    data     = word;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:   data = {{24{b_sel[7]}}, b_sel};
      F3_LBU:  data = {24'h000000, b_sel};
      F3_LH: begin
        data     = {{16{h_sel[15]}}, h_sel};
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        data     = {16'h0000, h_sel};
        misalign = addr_lo[0];
      end
      F3_LW:   misalign = |addr_lo;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32E writeback stage: commits ALU results or waits for load data, drives the register-file write port.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  bus
);

  localparam int unsigned CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  // Counter is 0 in the first WAIT_LOAD cycle, so the last waiting cycle holds LOAD_TIMEOUT-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 2);

  wb_state_e        state;
  load_req_t        req;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0]  align_data;
  logic             align_misalign;
  logic             align_illegal;

  logic             commit_c;
  logic [REG_W-1:0] commit_rd_c;
  logic [XLEN-1:0]  commit_data_c;
  logic             commit_err_c;

  load_align u_load_align (
    .funct3   (req.funct3),
    .addr_lo  (req.addr_lo),
    .word     (bus.mem_rdata),
    .data     (align_data),
    .misalign (align_misalign),
    .illegal  (align_illegal)
  );

  // Picks what (if anything) reaches the write port this cycle.
  always_comb begin
    commit_c      = 1'b0;
    commit_rd_c   = bus.ex_rd;
    commit_data_c = bus.ex_result;
    commit_err_c  = 1'b0;
    if (state == IDLE && bus.ex_valid && !bus.ex_is_load) begin
      commit_c = 1'b1;
    end else if (state == WAIT_LOAD && bus.mem_rvalid) begin
      commit_c      = 1'b1;
      commit_rd_c   = req.rd;
      commit_data_c = align_data;
      commit_err_c  = align_misalign | align_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      req              <= '0;
      cnt              <= '0;
      bus.ex_ready     <= 1'b1;
      bus.write_enable <= 1'b0;
      bus.rd           <= '0;
      bus.write_data   <= '0;
      bus.err          <= 1'b0;
    end else begin
      bus.write_enable <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.mem_rvalid) bus.err <= 1'b1;
          if (bus.ex_valid && bus.ex_is_load) begin
            req          <= '{rd: bus.ex_rd, funct3: bus.ex_funct3, addr_lo: bus.ex_addr_lo};
            cnt          <= '0;
            state        <= WAIT_LOAD;
            bus.ex_ready <= 1'b0;
          end
        end
        WAIT_LOAD: begin
          if (bus.mem_rvalid) begin
            state        <= IDLE;
            bus.ex_ready <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            bus.err      <= 1'b1;
            state        <= IDLE;
            bus.ex_ready <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state        <= IDLE;
          bus.ex_ready <= 1'b1;
        end
      endcase

      // x0 writes are silently dropped; indices above 15 do not exist in RV32E.
      if (commit_c) begin
        if (commit_err_c) bus.err <= 1'b1;
        if (commit_rd_c[REG_W-1]) begin
          bus.err <= 1'b1;
        end else if (commit_rd_c != '0) begin
          bus.write_enable <= 1'b1;
          bus.rd           <= commit_rd_c;
          bus.write_data   <= commit_data_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, multi-cycle corner sequences, random run against a reference model.
module tb_wb_stage;

  localparam int T_MAIN  = 16;
  localparam int T_SHORT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_if bus ();
  wb_if bus2 ();

  wb_stage #(.LOAD_TIMEOUT(T_MAIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_stage #(.LOAD_TIMEOUT(T_SHORT)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 1'b0;  bus.ex_rd = '0;  bus.ex_result = '0;  bus.ex_is_load = 1'b0;
    bus.ex_funct3 = '0;   bus.ex_addr_lo = '0;  bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
    bus2.ex_valid = 1'b0; bus2.ex_rd = '0; bus2.ex_result = '0; bus2.ex_is_load = 1'b0;
    bus2.ex_funct3 = '0;  bus2.ex_addr_lo = '0; bus2.mem_rvalid = 1'b0; bus2.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Spec-level load formatting: shift/mask/subtract instead of bit slicing.
  function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] w, output bit bad);
    logic [31:0] v;
    int unsigned ai;
    ai  = 32'(a);
    bad = 1'b0;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * ai)) & 32'h0000_00FF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        bad = (ai % 2) == 1;
        v = (w >> (16 * (ai / 2))) & 32'h0000_FFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      3'b010: begin
        bad = (ai != 0);
        v = w;
      end
      default: begin
        bad = 1'b1;
        v = w;
      end
    endcase
    return v;
  endfunction

  typedef struct {
    bit          is_load;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] rdata;
    int          delay;
    bit          exp_we;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the random run.
  bit          m_busy, m_err, m_we;
  logic [4:0]  m_rd, m_lrd;
  logic [31:0] m_wd;
  logic [2:0]  m_f3;
  logic [1:0]  m_a;
  int          m_acc_cyc, m_delay, cyc;

  task automatic model_commit(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) begin
    end else if (r >= 5'd16) begin
      m_err = 1'b1;
    end else begin
      m_we = 1'b1;
      m_rd = r;
      m_wd = d;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_we = 0; m_rd = '0; m_wd = '0;
  endtask

  initial begin
    vec_t v;
    bit bad;
    logic [31:0] d;
    int r;

    // {is_load, rd, result, f3, addr_lo, rdata, delay, exp_we, exp_data, exp_err}
    vecs.push_back('{0, 5'd3,  32'hDEADBEEF, 3'b000, 2'd0, 32'h0,        0, 1, 32'hDEADBEEF, 0});
    vecs.push_back('{1, 5'd5,  32'h0,        3'b000, 2'd3, 32'h80112233, 2, 1, 32'hFFFFFF80, 0});
    vecs.push_back('{1, 5'd5,  32'h0,        3'b100, 2'd3, 32'h80112233, 2, 1, 32'h00000080, 0});
    vecs.push_back('{1, 5'd5,  32'h0,        3'b101, 2'd2, 32'h80112233, 2, 1, 32'h00008011, 0});
    vecs.push_back('{1, 5'd6,  32'h0,        3'b001, 2'd2, 32'h80112233, 1, 1, 32'hFFFF8011, 0});
    vecs.push_back('{1, 5'd7,  32'h0,        3'b000, 2'd0, 32'h80112233, 3, 1, 32'h00000033, 0});
    vecs.push_back('{1, 5'd7,  32'h0,        3'b100, 2'd1, 32'h80112233, 1, 1, 32'h00000022, 0});
    vecs.push_back('{1, 5'd8,  32'h0,        3'b010, 2'd0, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D, 0});
    vecs.push_back('{1, 5'd8,  32'h0,        3'b010, 2'd1, 32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 1});
    vecs.push_back('{1, 5'd9,  32'h0,        3'b001, 2'd1, 32'h80112233, 1, 1, 32'h00002233, 1});
    vecs.push_back('{1, 5'd9,  32'h0,        3'b011, 2'd0, 32'h12345678, 1, 1, 32'h12345678, 1});
    vecs.push_back('{0, 5'd0,  32'h11111111, 3'b000, 2'd0, 32'h0,        0, 0, 32'h0,        0});
    vecs.push_back('{0, 5'd17, 32'h22222222, 3'b000, 2'd0, 32'h0,        0, 0, 32'h0,        1});
    vecs.push_back('{1, 5'd0,  32'h0,        3'b010, 2'd0, 32'h33333333, 1, 0, 32'h0,        0});

    rst = 1'b1;
    idle_inputs();
    #2;
    chk("reset_we", 32'(bus.write_enable), 32'd0);
    chk("reset_rd", 32'(bus.rd), 32'd0);
    chk("reset_wd", bus.write_data, 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    do_reset();
    chk("ready_after_reset", 32'(bus.ex_ready), 32'd1);

    foreach (vecs[i]) begin
      v = vecs[i];
      do_reset();
      bus.ex_valid = 1'b1; bus.ex_is_load = v.is_load; bus.ex_rd = v.rd;
      bus.ex_result = v.result; bus.ex_funct3 = v.f3; bus.ex_addr_lo = v.a;
      tick();
      bus.ex_valid = 1'b0;
      if (v.is_load) begin
        repeat (v.delay - 1) tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.rdata;
        tick();
        bus.mem_rvalid = 1'b0;
      end
      chk($sformatf("vec%0d_we", i), 32'(bus.write_enable), 32'(v.exp_we));
      chk($sformatf("vec%0d_rd", i), 32'(bus.rd), v.exp_we ? 32'(v.rd) : 32'd0);
      chk($sformatf("vec%0d_data", i), bus.write_data, v.exp_data);
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(v.exp_err));
      tick();
      chk($sformatf("vec%0d_we_pulse", i), 32'(bus.write_enable), 32'd0);
    end

    // Back-to-back ALU writes.
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd3; bus.ex_result = 32'hDEADBEEF;
    tick();
    chk("b2b_we0", 32'(bus.write_enable), 32'd1);
    chk("b2b_data0", bus.write_data, 32'hDEADBEEF);
    bus.ex_rd = 5'd4; bus.ex_result = 32'h1;
    tick();
    bus.ex_valid = 1'b0;
    chk("b2b_we1", 32'(bus.write_enable), 32'd1);
    chk("b2b_rd1", 32'(bus.rd), 32'd4);
    chk("b2b_data1", bus.write_data, 32'h1);
    chk("b2b_err", 32'(bus.err), 32'd0);
    tick();
    chk("b2b_we_off", 32'(bus.write_enable), 32'd0);
    chk("b2b_hold", bus.write_data, 32'h1);

    // Back-pressure: load with rvalid 5 cycles after accept, ALU held behind it.
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
    bus.ex_funct3 = 3'b010; bus.ex_addr_lo = 2'd0;
    tick();
    bus.ex_is_load = 1'b0; bus.ex_rd = 5'd6; bus.ex_result = 32'h55;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("bp_ready_low%0d", k), 32'(bus.ex_ready), 32'd0);
      chk($sformatf("bp_we_low%0d", k), 32'(bus.write_enable), 32'd0);
      if (k == 5) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A5_0001;
      end
      tick();
    end
    bus.mem_rvalid = 1'b0;
    chk("bp_ready_back", 32'(bus.ex_ready), 32'd1);
    chk("bp_load_we", 32'(bus.write_enable), 32'd1);
    chk("bp_load_rd", 32'(bus.rd), 32'd5);
    chk("bp_load_data", bus.write_data, 32'hA5A5_0001);
    tick();
    bus.ex_valid = 1'b0;
    chk("bp_alu_we", 32'(bus.write_enable), 32'd1);
    chk("bp_alu_rd", 32'(bus.rd), 32'd6);
    chk("bp_alu_data", bus.write_data, 32'h55);
    tick();
    chk("bp_alu_pulse", 32'(bus.write_enable), 32'd0);

    // Short-timeout instance: back in IDLE 4 cycles after accept, err set, no write.
    do_reset();
    bus2.ex_valid = 1'b1; bus2.ex_is_load = 1'b1; bus2.ex_rd = 5'd2; bus2.ex_funct3 = 3'b010;
    tick();
    bus2.ex_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("to_ready_low%0d", k), 32'(bus2.ex_ready), 32'd0);
      chk($sformatf("to_err_low%0d", k), 32'(bus2.err), 32'd0);
      tick();
    end
    chk("to_ready_back", 32'(bus2.ex_ready), 32'd1);
    chk("to_err", 32'(bus2.err), 32'd1);
    chk("to_no_we", 32'(bus2.write_enable), 32'd0);
    bus2.mem_rvalid = 1'b1; bus2.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus2.mem_rvalid = 1'b0;
    chk("to_late_rvalid_we", 32'(bus2.write_enable), 32'd0);
    chk("to_late_rvalid_rd", 32'(bus2.rd), 32'd0);
    chk("to_late_rvalid_err", 32'(bus2.err), 32'd1);

    // Default instance: rvalid on the last waiting cycle still commits.
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9; bus.ex_funct3 = 3'b010;
    tick();
    bus.ex_valid = 1'b0;
    repeat (T_MAIN - 2) tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("late_load_we", 32'(bus.write_enable), 32'd1);
    chk("late_load_data", bus.write_data, 32'hCAFE_F00D);
    chk("late_load_err", 32'(bus.err), 32'd0);

    // Default instance: no rvalid at all times out in cycle N+16.
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9; bus.ex_funct3 = 3'b010;
    tick();
    bus.ex_valid = 1'b0;
    repeat (T_MAIN - 2) tick();
    chk("main_to_still_wait", 32'(bus.ex_ready), 32'd0);
    chk("main_to_err_pre", 32'(bus.err), 32'd0);
    tick();
    chk("main_to_ready", 32'(bus.ex_ready), 32'd1);
    chk("main_to_err", 32'(bus.err), 32'd1);
    chk("main_to_we", 32'(bus.write_enable), 32'd0);

    // Asynchronous reset while waiting on a load, with rvalid already presented.
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd7; bus.ex_result = 32'h1234;
    tick();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd8; bus.ex_funct3 = 3'b010;
    tick();
    bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0;
    chk("rst_pre_rd", 32'(bus.rd), 32'd7);
    chk("rst_pre_ready", 32'(bus.ex_ready), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we", 32'(bus.write_enable), 32'd0);
    chk("rst_async_rd", 32'(bus.rd), 32'd0);
    chk("rst_async_wd", bus.write_data, 32'd0);
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b0;
    tick();
    chk("rst_post_we", 32'(bus.write_enable), 32'd0);
    chk("rst_post_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_post_err", 32'(bus.err), 32'd0);
    chk("rst_post_wd", bus.write_data, 32'd0);

    // Random traffic against the reference model, re-reset periodically so err stays observable.
    cyc = 0;
    for (int blk = 0; blk < 10; blk++) begin
      do_reset();
      model_reset();
      for (int n = 0; n < 300; n++) begin
        bus.ex_valid   = ($urandom_range(0, 9) < 6);
        bus.ex_is_load = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 19));
        if (r == 19)      bus.ex_rd = 5'd0;
        else if (r == 18) bus.ex_rd = 5'($urandom_range(16, 31));
        else              bus.ex_rd = 5'($urandom_range(1, 15));
        bus.ex_result  = $urandom;
        bus.ex_funct3  = 3'($urandom);
        bus.ex_addr_lo = 2'($urandom);
        bus.mem_rdata  = $urandom;
        if (m_busy) bus.mem_rvalid = ((cyc - m_acc_cyc) == m_delay);
        else        bus.mem_rvalid = ($urandom_range(0, 29) == 0);

        m_we = 1'b0;
        if (!m_busy) begin
          if (bus.mem_rvalid) m_err = 1'b1;
          if (bus.ex_valid) begin
            if (bus.ex_is_load) begin
              m_busy = 1'b1; m_acc_cyc = cyc; m_lrd = bus.ex_rd;
              m_f3 = bus.ex_funct3; m_a = bus.ex_addr_lo;
              m_delay = int'($urandom_range(1, 18));
            end else begin
              model_commit(bus.ex_rd, bus.ex_result);
            end
          end
        end else if (bus.mem_rvalid) begin
          d = ref_fmt(m_f3, m_a, bus.mem_rdata, bad);
          if (bad) m_err = 1'b1;
          model_commit(m_lrd, d);
          m_busy = 1'b0;
        end else if ((cyc - m_acc_cyc) == T_MAIN - 1) begin
          m_err = 1'b1;
          m_busy = 1'b0;
        end

        tick();
        cyc++;
        chk("rnd_we", 32'(bus.write_enable), 32'(m_we));
        chk("rnd_ready", 32'(bus.ex_ready), 32'(!m_busy));
        chk("rnd_err", 32'(bus.err), 32'(m_err));
        chk("rnd_rd", 32'(bus.rd), 32'(m_rd));
        chk("rnd_wd", bus.write_data, m_wd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
